// File: rtl/result_collector_pkg.sv
// result_collector_pkg: shared types, default sizes and the round-robin helper
// for the result collector. The optional timestamp feature is selected in the
// top with RESULT_COLLECTOR_TSTAMP_EN.
package result_collector_pkg;

  localparam int RC_BLOCKS    = 192;
  localparam int RC_ID_WIDTH  = 8;
  localparam int RC_WORD_BITS = 64;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } coll_state_t;

  // Successor of a block index in round-robin order, wrapping blocks-1 -> 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned blocks);
    return (ptr >= blocks - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/result_collector_bit_deserializer.sv
// bit_deserializer: collects WORD_BITS serial bits, LSB first, into a word.
// done pulses combinationally in the cycle whose posedge stores the last bit.
module bit_deserializer
  import result_collector_pkg::*;
#(
  parameter int WORD_BITS = RC_WORD_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [WORD_BITS-1:0] word,
  output logic                 done
);

  localparam int CNT_W = $clog2(WORD_BITS);

  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;

  // Store the presented bit at the current position and advance the counter.
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    done     = 1'b0;
    if (shift_en) begin
      shreg_d[bitcnt_q] = bit_in;
      if (bitcnt_q == CNT_W'(WORD_BITS - 1)) begin
        done     = 1'b1;
        bitcnt_d = '0;
      end else begin
        bitcnt_d = bitcnt_q + 1'b1;
      end
    end
  end

  // Reset drops any partial record so a new shift always starts at bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign word = shreg_q;

endmodule

// File: rtl/result_collector.sv
// result_collector: round-robin drain of the hash block result FIFOs onto a
// valid/ready stream, plus sticky per-block overflow status.
// Optional feature: define RESULT_COLLECTOR_TSTAMP_EN to add a free-running
// cycle counter sampled at shift entry and presented on out_tstamp.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int BLOCKS    = RC_BLOCKS,
  parameter int ID_WIDTH  = RC_ID_WIDTH,
  parameter int WORD_BITS = RC_WORD_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BLOCKS-1:0]    fifo_empty,
  input  logic [BLOCKS-1:0]    fifo_oflow,
  input  logic [BLOCKS-1:0]    fifo_bits,
  output logic [BLOCKS-1:0]    fifo_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_WIDTH-1:0]  out_block,
  output logic [WORD_BITS-1:0] out_data,
`ifdef RESULT_COLLECTOR_TSTAMP_EN
  output logic [31:0]          out_tstamp,
`endif
  input  logic                 oflow_clr,
  output logic                 oflow_any,
  output logic [ID_WIDTH-1:0]  oflow_first
);

  coll_state_t         state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] idx_q, idx_d;
  logic [BLOCKS-1:0]   sticky_q, sticky_d;
  logic                oflow_any_q, oflow_any_d;
  logic [ID_WIDTH-1:0] oflow_first_q, oflow_first_d;
  logic                shift_en;
  logic                cur_bit;
  logic                deser_done;

  assign shift_en = (state_q == SHIFT);
  assign cur_bit  = fifo_bits[idx_q];

  bit_deserializer #(
    .WORD_BITS (WORD_BITS)
  ) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .bit_in   (cur_bit),
    .word     (out_data),
    .done     (deser_done)
  );

  // Scan one index per cycle, shift the found block, hold the record until taken.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      SCAN: begin
        if (!fifo_empty[ptr_q]) begin
          idx_d   = ptr_q;
          state_d = SHIFT;
        end else begin
          ptr_d = ID_WIDTH'(rr_next(32'(ptr_q), BLOCKS));
        end
      end
      SHIFT: begin
        if (deser_done) state_d = EMIT;
      end
      EMIT: begin
        // Resume after the served block so every other block is seen first.
        if (out_ready) begin
          state_d = SCAN;
          ptr_d   = ID_WIDTH'(rr_next(32'(idx_q), BLOCKS));
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // One-hot shift strobe toward the block being drained.
  always_comb begin
    fifo_req = '0;
    if (state_q == SHIFT) fifo_req[idx_q] = 1'b1;
  end

  // Sticky overflow with clear priority; summary flags lag sticky by one cycle.
  always_comb begin
    sticky_d      = (sticky_q | fifo_oflow) & ~{BLOCKS{oflow_clr}};
    oflow_any_d   = |sticky_q;
    oflow_first_d = '0;
    for (int i = BLOCKS - 1; i >= 0; i--) begin
      if (sticky_q[i]) oflow_first_d = ID_WIDTH'(i);
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= SCAN;
      ptr_q         <= '0;
      idx_q         <= '0;
      sticky_q      <= '0;
      oflow_any_q   <= 1'b0;
      oflow_first_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      sticky_q      <= sticky_d;
      oflow_any_q   <= oflow_any_d;
      oflow_first_q <= oflow_first_d;
    end
  end

  assign out_valid   = (state_q == EMIT);
  assign out_block   = idx_q;
  assign oflow_any   = oflow_any_q;
  assign oflow_first = oflow_first_q;

`ifdef RESULT_COLLECTOR_TSTAMP_EN
  logic [31:0] cyc_q, cyc_d, tstamp_q, tstamp_d;

  // Timestamp is the counter value seen during the first SHIFT cycle.
  always_comb begin
    cyc_d    = cyc_q + 32'd1;
    tstamp_d = tstamp_q;
    if (state_q == SCAN && state_d == SHIFT) tstamp_d = cyc_q + 32'd1;
  end

  // Free-running cycle counter and captured timestamp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q    <= '0;
      tstamp_q <= '0;
    end else begin
      cyc_q    <= cyc_d;
      tstamp_q <= tstamp_d;
    end
  end

  assign out_tstamp = tstamp_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed bench for result_collector with a behavioural
// model of the block array FIFOs. Exercises the timestamp output when
// RESULT_COLLECTOR_TSTAMP_EN is defined.
module tb_result_collector;

  localparam int BLOCKS    = 192;
  localparam int ID_WIDTH  = 8;
  localparam int WORD_BITS = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [BLOCKS-1:0]    fifo_empty, fifo_oflow, fifo_bits, fifo_req;
  logic                 out_valid, out_ready;
  logic [ID_WIDTH-1:0]  out_block, oflow_first;
  logic [WORD_BITS-1:0] out_data;
  logic                 oflow_clr, oflow_any;
`ifdef RESULT_COLLECTOR_TSTAMP_EN
  logic [31:0]          out_tstamp;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  result_collector #(
    .BLOCKS    (BLOCKS),
    .ID_WIDTH  (ID_WIDTH),
    .WORD_BITS (WORD_BITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_oflow  (fifo_oflow),
    .fifo_bits   (fifo_bits),
    .fifo_req    (fifo_req),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_block   (out_block),
    .out_data    (out_data),
`ifdef RESULT_COLLECTOR_TSTAMP_EN
    .out_tstamp  (out_tstamp),
`endif
    .oflow_clr   (oflow_clr),
    .oflow_any   (oflow_any),
    .oflow_first (oflow_first)
  );

  // Block array model: per-block record FIFO with a serial bit pointer.
  logic [63:0] rec  [BLOCKS][8];
  logic [2:0]  nrec [BLOCKS];
  logic [5:0]  bptr [BLOCKS];
  logic        model_clr;
  logic        push_en;
  logic [7:0]  push_blk;
  logic [63:0] push_data;

  always_comb begin
    for (int i = 0; i < BLOCKS; i++) begin
      fifo_empty[i] = (nrec[i] == 3'd0);
      fifo_bits[i]  = rec[i][0][bptr[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < BLOCKS; i++) begin
        nrec[i] <= '0;
        bptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BLOCKS; i++) begin
        if (!rst_n) begin
          bptr[i] <= '0;
        end else if (fifo_req[i]) begin
          bptr[i] <= bptr[i] + 6'd1;
          if (bptr[i] == 6'd63) begin
            for (int k = 0; k < 7; k++) rec[i][k] <= rec[i][k+1];
            nrec[i] <= nrec[i] - 3'd1;
          end
        end
      end
      if (push_en) begin
        rec[push_blk][nrec[push_blk]] <= push_data;
        nrec[push_blk]                <= nrec[push_blk] + 3'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic push(input logic [7:0] blk, input logic [63:0] data);
    push_en   = 1'b1;
    push_blk  = blk;
    push_data = data;
    @(negedge clk);
    push_en   = 1'b0;
  endtask

  int   req_cnt;
  logic stray;

  task automatic wait_valid(input logic [7:0] blk, input int max_cyc);
    req_cnt = 0;
    stray   = 1'b0;
    for (int c = 0; c < max_cyc && !out_valid; c++) begin
      if (fifo_req[blk]) req_cnt++;
      if ((fifo_req & ~(BLOCKS'(1) << blk)) != '0) stray = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [7:0]  t2_blk [6] = '{8'd3, 8'd7, 8'd191, 8'd3, 8'd7, 8'd191};
  logic [63:0] t2_dat [6] = '{64'h0003_0000_AAAA_0001, 64'h0007_0000_BBBB_0001,
                              64'h00BF_0000_CCCC_0001, 64'h0003_0000_AAAA_0002,
                              64'h0007_0000_BBBB_0002, 64'h00BF_0000_CCCC_0002};
  logic        stable;
  int          found;

  initial begin
    rst_n      = 1'b0;
    model_clr  = 1'b1;
    push_en    = 1'b0;
    push_blk   = '0;
    push_data  = '0;
    fifo_oflow = '0;
    oflow_clr  = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    model_clr = 1'b0;

    // Reset state
    check("rst_fifo_req",    64'(fifo_req),    64'd0);
    check("rst_out_valid",   64'(out_valid),   64'd0);
    check("rst_out_block",   64'(out_block),   64'd0);
    check("rst_out_data",    out_data,         64'd0);
    check("rst_oflow_any",   64'(oflow_any),   64'd0);
    check("rst_oflow_first", 64'(oflow_first), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single record from block 5
    push(8'd5, 64'hDEAD_BEEF_0123_4567);
    wait_valid(8'd5, 400);
    check("t1_valid",   64'(out_valid), 64'd1);
    check("t1_req_cnt", 64'(req_cnt),   64'd64);
    check("t1_stray",   64'(stray),     64'd0);
    check("t1_block",   64'(out_block), 64'd5);
    check("t1_data",    out_data,       64'hDEAD_BEEF_0123_4567);

    // Back-pressure: 100+ cycles of out_ready=0 with another block pending
    push(8'd6, 64'h0123_4567_89AB_CDEF);
    stable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_block !== 8'd5 ||
          out_data !== 64'hDEAD_BEEF_0123_4567 || fifo_req !== '0) stable = 1'b0;
    end
    check("t3_stable", 64'(stable), 64'd1);
    accept();
    check("t3_accepted", 64'(out_valid), 64'd0);
    wait_valid(8'd6, 400);
    check("t3_next_block", 64'(out_block), 64'd6);
    check("t3_next_data",  out_data,       64'h0123_4567_89AB_CDEF);
    accept();

    // Round-robin order and wrap, records loaded while held in reset
    rst_n = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 6; j++) push(t2_blk[j], t2_dat[j]);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      wait_valid(t2_blk[j], 400);
      check($sformatf("t2_valid_%0d", j), 64'(out_valid), 64'd1);
      check($sformatf("t2_block_%0d", j), 64'(out_block), 64'(t2_blk[j]));
      check($sformatf("t2_data_%0d", j),  out_data,       t2_dat[j]);
      @(negedge clk);
    end
    out_ready = 1'b0;

    // Sticky overflow: latency, lowest index, clear
    fifo_oflow[42] = 1'b1;
    @(negedge clk);
    fifo_oflow[42] = 1'b0;
    check("t4_any_latency", 64'(oflow_any), 64'd0);
    @(negedge clk);
    check("t4_any_42",   64'(oflow_any),   64'd1);
    check("t4_first_42", 64'(oflow_first), 64'd42);
    fifo_oflow[100] = 1'b1;
    @(negedge clk);
    fifo_oflow[100] = 1'b0;
    @(negedge clk);
    check("t4_first_keep_42", 64'(oflow_first), 64'd42);
    fifo_oflow[7] = 1'b1;
    @(negedge clk);
    fifo_oflow[7] = 1'b0;
    @(negedge clk);
    check("t4_first_7", 64'(oflow_first), 64'd7);
    oflow_clr = 1'b1;
    @(negedge clk);
    oflow_clr = 1'b0;
    @(negedge clk);
    check("t4_clr_any",   64'(oflow_any),   64'd0);
    check("t4_clr_first", 64'(oflow_first), 64'd0);

    // Clear and overflow together: clear wins, bit re-sets next cycle
    fifo_oflow[10] = 1'b1;
    oflow_clr      = 1'b1;
    @(negedge clk);
    oflow_clr = 1'b0;
    @(negedge clk);
    check("t4_clr_wins", 64'(oflow_any), 64'd0);
    @(negedge clk);
    check("t4_reset_any",   64'(oflow_any),   64'd1);
    check("t4_reset_first", 64'(oflow_first), 64'd10);
    fifo_oflow[10] = 1'b0;
    oflow_clr      = 1'b1;
    @(negedge clk);
    oflow_clr = 1'b0;
    @(negedge clk);
    check("t4_final_clr", 64'(oflow_any), 64'd0);

    // Reset in the middle of a shift
    rst_n = 1'b0;
    @(negedge clk);
    push(8'd9, 64'hFEDC_BA98_7654_3210);
    rst_n = 1'b1;
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      if (fifo_req[9]) found = 1;
      else @(negedge clk);
    end
    check("t5_shift_seen", 64'(found), 64'd1);
    repeat (30) @(negedge clk);
    check("t5_req_at_30", 64'(fifo_req[9]), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_req_dropped", 64'(fifo_req),  64'd0);
    check("t5_no_valid",    64'(out_valid), 64'd0);
    rst_n = 1'b1;
    wait_valid(8'd9, 400);
    check("t5_valid",   64'(out_valid), 64'd1);
    check("t5_req_cnt", 64'(req_cnt),   64'd64);
    check("t5_block",   64'(out_block), 64'd9);
    check("t5_data",    out_data,       64'hFEDC_BA98_7654_3210);
    accept();

`ifdef RESULT_COLLECTOR_TSTAMP_EN
    // Block 39 becomes visible in cycle 901; the sweep reaches it in cycle 999
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (900) @(negedge clk);
    push(8'd39, 64'h1111_2222_3333_4444);
    wait_valid(8'd39, 400);
    check("t6_block",  64'(out_block),  64'd39);
    check("t6_tstamp", 64'(out_tstamp), 64'd1000);
    accept();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
